// File: rtl/lsu_dmem.sv
// Load/store unit with a byte-addressable 32-bit word data memory (RV32I widths).
// Define LSU_DMEM_MISALIGN_EN to split word-crossing accesses into two beats; otherwise misaligned accesses error out.
module lsu_dmem #(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    output logic              o_ready,
    input  logic              i_wren,
    input  logic [2:0]        i_func3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_rvalid,
    output logic [31:0]       o_rdata,
    output logic              o_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1
`ifdef LSU_DMEM_MISALIGN_EN
        ,
        BEAT2 = 2'd2
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    idx_t        idx;
    logic [1:0]  off;
    logic [4:0]  sh;
    logic [3:0]  smask;
    logic [3:0]  mask_lo;
    logic [31:0] wdata_lo;
    logic [31:0] word_rd;
    logic        legal;
    logic        reject;

    logic [3:0]  mem_we;
    idx_t        mem_widx;
    logic [31:0] mem_wdata;

`ifdef LSU_DMEM_MISALIGN_EN
    logic        crossing;
    idx_t        nxt_idx_q, nxt_idx_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  off_q, off_d;
    logic        wren_q, wren_d;
    logic [31:0] lo_word_q, lo_word_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [3:0]  hi_mask_q, hi_mask_d;
`else
    logic        misaligned;
`endif

    logic unused_addr;
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
        assign unused_addr = ^i_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_addr_exact
        assign unused_addr = 1'b0;
    end

    function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'b0, raw[7:0]};
            3'b101:  return {16'b0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign o_ready  = (state_q == IDLE);
    assign o_rvalid = rvalid_q;
    assign o_err    = err_q;
    assign o_rdata  = rdata_q;

    // Request decode: lane mask and data are shifted into position by the byte offset.
    always_comb begin
        accept   = i_req && o_ready && !i_reset;
        idx      = i_addr[IDX_W+1:2];
        off      = i_addr[1:0];
        sh       = {off, 3'b000};
        case (i_func3[1:0])
            2'b00:   smask = 4'b0001;
            2'b01:   smask = 4'b0011;
            default: smask = 4'b1111;
        endcase
        mask_lo  = smask << off;
        wdata_lo = i_wdata << sh;
        word_rd  = mem[idx];
        legal    = (i_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                   && !(i_wren && i_func3[2]);
`ifdef LSU_DMEM_MISALIGN_EN
        crossing = (i_func3[1:0] == 2'b01 && off == 2'd3)
                   || (i_func3[1:0] == 2'b10 && off != 2'd0);
        reject   = !legal;
`else
        misaligned = (i_func3[1:0] == 2'b01 && off[0])
                     || (i_func3[1:0] == 2'b10 && off != 2'd0);
        reject     = !legal || misaligned;
`endif
    end

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        rdata_d   = '0;
        mem_we    = '0;
        mem_widx  = idx;
        mem_wdata = wdata_lo;
`ifdef LSU_DMEM_MISALIGN_EN
        nxt_idx_d  = nxt_idx_q;
        func3_d    = func3_q;
        off_d      = off_q;
        wren_d     = wren_q;
        lo_word_d  = lo_word_q;
        hi_wdata_d = hi_wdata_q;
        hi_mask_d  = hi_mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                    end
`ifdef LSU_DMEM_MISALIGN_EN
                    else if (crossing) begin
                        state_d    = BEAT2;
                        mem_we     = i_wren ? mask_lo : 4'b0000;
                        nxt_idx_d  = idx + idx_t'(1);
                        func3_d    = i_func3;
                        off_d      = off;
                        wren_d     = i_wren;
                        lo_word_d  = word_rd;
                        hi_wdata_d = i_wdata >> (6'd32 - {1'b0, sh});
                        hi_mask_d  = smask >> (3'd4 - {1'b0, off});
                    end
`endif
                    else begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        if (i_wren) begin
                            mem_we = mask_lo;
                        end else begin
                            rdata_d = load_ext(word_rd >> sh, i_func3);
                        end
                    end
                end
            end
`ifdef LSU_DMEM_MISALIGN_EN
            BEAT2: begin
                state_d  = RESP;
                rvalid_d = 1'b1;
                if (wren_q) begin
                    mem_we    = hi_mask_q;
                    mem_widx  = nxt_idx_q;
                    mem_wdata = hi_wdata_q;
                end else begin
                    // Low bytes come from the word captured at acceptance, high bytes from word N+1.
                    rdata_d = load_ext((lo_word_q >> {off_q, 3'b000})
                                       | (mem[nxt_idx_q] << (6'd32 - {1'b0, off_q, 3'b000})),
                                       func3_q);
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_reset) begin
            mem_we = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef LSU_DMEM_MISALIGN_EN
            nxt_idx_q  <= '0;
            func3_q    <= '0;
            off_q      <= '0;
            wren_q     <= 1'b0;
            lo_word_q  <= '0;
            hi_wdata_q <= '0;
            hi_mask_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
`ifdef LSU_DMEM_MISALIGN_EN
            nxt_idx_q  <= nxt_idx_d;
            func3_q    <= func3_d;
            off_q      <= off_d;
            wren_q     <= wren_d;
            lo_word_q  <= lo_word_d;
            hi_wdata_q <= hi_wdata_d;
            hi_mask_q  <= hi_mask_d;
`endif
        end
    end

    // NOTE: the array is deliberately left out of reset so it maps onto RAM and keeps contents across resets.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) begin
                mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed self-checking bench for lsu_dmem; adapts to LSU_DMEM_MISALIGN_EN.
module tb_lsu_dmem;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req;
    logic        o_ready;
    logic        i_wren;
    logic [2:0]  i_func3;
    logic [15:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    lsu_dmem #(.DEPTH_WORDS(512), .ADDR_W(16)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (i_req),
        .o_ready (o_ready),
        .i_wren  (i_wren),
        .i_func3 (i_func3),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .o_rvalid(o_rvalid),
        .o_rdata (o_rdata),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction; hs_ok covers ready low while busy, single-cycle rvalid and ready back afterwards.
    task automatic access(input logic wren, input logic [2:0] f3, input logic [15:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output logic hs_ok);
        @(negedge i_clk);
        i_req = 1'b1; i_wren = wren; i_func3 = f3; i_addr = addr; i_wdata = wdata;
        @(posedge i_clk);
        #1;
        i_req = 1'b0; i_wren = 1'b0;
        lat = 0; rdata = 32'hFFFF_FFFF; err = 1'b1; hs_ok = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge i_clk);
            if (o_ready !== 1'b0) hs_ok = 1'b0;
            if (o_rvalid === 1'b1) begin
                lat = c; rdata = o_rdata; err = o_err;
                break;
            end
        end
        @(posedge i_clk);
        #1;
        if (o_rvalid !== 1'b0 || o_ready !== 1'b1) hs_ok = 1'b0;
    endtask

    task automatic run(input string tag, input logic wren, input logic [2:0] f3,
                       input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        ok;
        access(wren, f3, addr, wdata, rd, er, lat, ok);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rd, exp_data);
        check({tag, " err"}, {31'b0, er}, {31'b0, exp_err});
        check({tag, " handshake"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic st(input string tag, input logic [2:0] f3, input logic [15:0] addr,
                      input logic [31:0] wdata, input int exp_lat);
        run(tag, 1'b1, f3, addr, wdata, 32'h0, 1'b0, exp_lat);
    endtask

    task automatic ld(input string tag, input logic [2:0] f3, input logic [15:0] addr,
                      input logic [31:0] exp_data, input int exp_lat);
        run(tag, 1'b0, f3, addr, 32'h0, exp_data, 1'b0, exp_lat);
    endtask

    task automatic bad(input string tag, input logic wren, input logic [2:0] f3,
                       input logic [15:0] addr, input logic [31:0] wdata);
        run(tag, wren, f3, addr, wdata, 32'h0, 1'b1, 1);
    endtask

    initial begin
        logic rv_seen;
        i_reset = 1'b1; i_req = 1'b0; i_wren = 1'b0; i_func3 = '0; i_addr = '0; i_wdata = '0;
        repeat (2) @(negedge i_clk);
        check("reset rvalid", {31'b0, o_rvalid}, 32'd0);
        check("reset err", {31'b0, o_err}, 32'd0);
        check("reset rdata", o_rdata, 32'h0);
        i_reset = 1'b0;
        check("ready after release", {31'b0, o_ready}, 32'd1);

        st("sw 0x10", F_W, 16'h0010, 32'hDEAD_BEEF, 1);
        ld("lw 0x10", F_W, 16'h0010, 32'hDEAD_BEEF, 1);

        st("sw 0x20", F_W, 16'h0020, 32'h1122_3344, 1);
        st("sb 0x21", F_B, 16'h0021, 32'h0000_0080, 1);
        ld("lb 0x21", F_B, 16'h0021, 32'hFFFF_FF80, 1);
        ld("lbu 0x21", F_BU, 16'h0021, 32'h0000_0080, 1);
        ld("lw 0x20", F_W, 16'h0020, 32'h1122_8044, 1);
        ld("lh 0x22", F_H, 16'h0022, 32'h0000_1122, 1);
        ld("lhu 0x20", F_HU, 16'h0020, 32'h0000_8044, 1);
        ld("lh 0x20", F_H, 16'h0020, 32'hFFFF_8044, 1);

        st("sw 0x30", F_W, 16'h0030, 32'h0000_0000, 1);
        st("sh 0x32", F_H, 16'h0032, 32'h1234_BEEF, 1);
        ld("lw 0x30 a", F_W, 16'h0030, 32'hBEEF_0000, 1);
        ld("lb 0x33", F_B, 16'h0033, 32'hFFFF_FFBE, 1);
        st("sb 0x30", F_B, 16'h0030, 32'hFFFF_FF7F, 1);
        ld("lw 0x30 b", F_W, 16'h0030, 32'hBEEF_007F, 1);

        bad("ld f3 011", 1'b0, 3'b011, 16'h0010, 32'h0);
        bad("st f3 100", 1'b1, 3'b100, 16'h0010, 32'h0000_00FF);
        bad("ld f3 110", 1'b0, 3'b110, 16'h0010, 32'h0);
        bad("st f3 111", 1'b1, 3'b111, 16'h0010, 32'h0);
        ld("lw 0x10 after illegal", F_W, 16'h0010, 32'hDEAD_BEEF, 1);

        st("sw 0x40", F_W, 16'h0040, 32'hCAFE_F00D, 1);
        ld("lw 0x40 back-to-back", F_W, 16'h0040, 32'hCAFE_F00D, 1);

`ifdef LSU_DMEM_MISALIGN_EN
        st("sw 0x0 clr", F_W, 16'h0000, 32'h0, 1);
        st("sw 0x4 clr", F_W, 16'h0004, 32'h0, 1);
        st("sw 0x3 split", F_W, 16'h0003, 32'h1122_3344, 2);
        ld("lw 0x3 split", F_W, 16'h0003, 32'h1122_3344, 2);
        ld("lbu 0x4", F_BU, 16'h0004, 32'h0000_0033, 1);
        ld("lbu 0x5", F_BU, 16'h0005, 32'h0000_0022, 1);
        ld("lw 0x0 low part", F_W, 16'h0000, 32'h4400_0000, 1);
        ld("lw 0x4 high part", F_W, 16'h0004, 32'h0011_2233, 1);
        ld("lhu 0x2 in-word", F_HU, 16'h0002, 32'h0000_4400, 1);
        ld("lh 0x3 split", F_H, 16'h0003, 32'h0000_3344, 2);

        st("sw 0x7fc clr", F_W, 16'h07FC, 32'h0, 1);
        st("sw 0x0 clr2", F_W, 16'h0000, 32'h0, 1);
        st("sh 0x7ff wrap", F_H, 16'h07FF, 32'h0000_A55A, 2);
        ld("lbu 0x7ff", F_BU, 16'h07FF, 32'h0000_005A, 1);
        ld("lbu 0x0 wrap", F_BU, 16'h0000, 32'h0000_00A5, 1);
        ld("lh 0x7ff wrap", F_H, 16'h07FF, 32'hFFFF_A55A, 2);
        ld("lw 0x7fc", F_W, 16'h07FC, 32'h5A00_0000, 1);

        st("sw 0x4 pre", F_W, 16'h0004, 32'h5566_7788, 1);
        st("sw 0x0 pre", F_W, 16'h0000, 32'h0, 1);
        @(negedge i_clk);
        i_req = 1'b1; i_wren = 1'b1; i_func3 = F_W; i_addr = 16'h0003; i_wdata = 32'hCAFE_BABE;
        @(posedge i_clk);
        #1;
        i_req = 1'b0; i_wren = 1'b0;
        @(negedge i_clk);
        check("beat2 ready low", {31'b0, o_ready}, 32'd0);
        i_reset = 1'b1;
        #1;
        check("beat2 abort ready", {31'b0, o_ready}, 32'd1);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("beat2 ready after release", {31'b0, o_ready}, 32'd1);
        rv_seen = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_rvalid !== 1'b0) rv_seen = 1'b1;
        end
        check("beat2 abort no rvalid", {31'b0, rv_seen}, 32'd0);
        ld("lw 0x4 untouched", F_W, 16'h0004, 32'h5566_7788, 1);
        ld("lw 0x0 low kept", F_W, 16'h0000, 32'hBE00_0000, 1);
`else
        bad("lw 0x12 misaligned", 1'b0, F_W, 16'h0012, 32'h0);
        bad("lh 0x11 misaligned", 1'b0, F_H, 16'h0011, 32'h0);
        bad("sw 0x13 misaligned", 1'b1, F_W, 16'h0013, 32'h0000_0000);
        bad("sh 0x7ff misaligned", 1'b1, F_H, 16'h07FF, 32'h0000_A55A);
        ld("lw 0x10 after misaligned", F_W, 16'h0010, 32'hDEAD_BEEF, 1);
        ld("lh 0x12 aligned", F_H, 16'h0012, 32'hFFFF_DEAD, 1);
        ld("lbu 0x13", F_BU, 16'h0013, 32'h0000_00DE, 1);
`endif

        @(negedge i_clk);
        i_req = 1'b1; i_wren = 1'b0; i_func3 = F_W; i_addr = 16'h0010; i_wdata = '0;
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        check("resp rvalid before reset", {31'b0, o_rvalid}, 32'd1);
        i_reset = 1'b1;
        #1;
        check("resp reset rvalid", {31'b0, o_rvalid}, 32'd0);
        check("resp reset rdata", o_rdata, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("resp ready after release", {31'b0, o_ready}, 32'd1);
        ld("lw 0x10 after reset", F_W, 16'h0010, 32'hDEAD_BEEF, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
